// File: rtl/type_parameterized_fifo.sv
// Show-ahead synchronous FIFO, generic in element type and depth, with valid/ready
// handshakes on both sides, occupancy, almost-full flag and a high-water mark.
module type_parameterized_fifo #(
   parameter type DATA_TYPE         = logic [7:0],
   parameter int  DEPTH             = 4,
   parameter int  ALMOST_FULL_LEVEL = DEPTH - 1,
   localparam int CW                = $clog2(DEPTH + 1),
   localparam int PW                = $clog2(DEPTH)
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           flush,
   input  logic           in_valid,
   output logic           in_ready,
   input  DATA_TYPE       in_data,
   output logic           out_valid,
   input  logic           out_ready,
   output DATA_TYPE       out_data,
   output logic [CW-1:0]  count,
   output logic           almost_full,
   output logic [CW-1:0]  peak_count
);

   DATA_TYPE      mem [DEPTH];
   logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
   logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
   logic [CW-1:0] count_reg, count_next;
   logic [CW-1:0] peak_reg, peak_next;
   logic          almost_full_reg, almost_full_next;
   logic          push, pop;

   // Explicit compare so non-power-of-two depths wrap correctly.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
      return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
   endfunction

   assign in_ready    = !reset && (count_reg < CW'(DEPTH));
   assign out_valid   = (count_reg != '0);
   assign push        = in_valid && in_ready;
   assign pop         = out_valid && out_ready;
   assign out_data    = out_valid ? mem[rd_ptr_reg] : DATA_TYPE'('0);
   assign count       = count_reg;
   assign almost_full = almost_full_reg;
   assign peak_count  = peak_reg;

   always_comb begin
      wr_ptr_next = wr_ptr_reg;
      rd_ptr_next = rd_ptr_reg;
      count_next  = count_reg;
      if (flush) begin
         wr_ptr_next = '0;
         rd_ptr_next = '0;
         count_next  = '0;
      end else begin
         if (push) wr_ptr_next = ptr_inc(wr_ptr_reg);
         if (pop)  rd_ptr_next = ptr_inc(rd_ptr_reg);
         if (push && !pop)      count_next = count_reg + CW'(1);
         else if (pop && !push) count_next = count_reg - CW'(1);
      end
      peak_next        = (count_next > peak_reg) ? count_next : peak_reg;
      almost_full_next = (count_next >= CW'(ALMOST_FULL_LEVEL));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_reg      <= '0;
         rd_ptr_reg      <= '0;
         count_reg       <= '0;
         peak_reg        <= '0;
         almost_full_reg <= 1'b0;
      end else begin
         wr_ptr_reg      <= wr_ptr_next;
         rd_ptr_reg      <= rd_ptr_next;
         count_reg       <= count_next;
         peak_reg        <= peak_next;
         almost_full_reg <= almost_full_next;
      end
   end

   // Storage has no reset; a flushed push is dropped so it never lands in memory.
   always_ff @(posedge clk) begin
      if (push && !flush)
         mem[wr_ptr_reg] <= in_data;
   end

endmodule

// File: tb/tb_type_parameterized_fifo.sv
// Self-checking bench: table-driven byte FIFO vectors, hand-written corner sequences
// for struct types, and a randomized run against a queue reference model.
module tb_type_parameterized_fifo;

   typedef struct packed {
      logic [7:0] red;
      logic [7:0] green;
      logic [7:0] blue;
   } rgb_color_t;

   typedef struct packed {
      logic [15:0] x;
      logic [15:0] y;
   } coordinate_t;

   logic clk = 1'b0;
   logic reset, flush;
   always #5 clk = ~clk;

   // byte FIFO, DEPTH 4
   logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_af;
   logic [7:0] b_in_data, b_out_data;
   logic [2:0] b_count, b_peak;

   // rgb FIFO, DEPTH 3
   logic       r_in_valid, r_in_ready, r_out_valid, r_out_ready, r_af;
   rgb_color_t r_in_data, r_out_data;
   logic [1:0] r_count, r_peak;

   // coordinate FIFO, DEPTH 3
   logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_af;
   coordinate_t c_in_data, c_out_data;
   logic [1:0]  c_count, c_peak;

   type_parameterized_fifo #(.DATA_TYPE(logic [7:0]), .DEPTH(4)) u_byte (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
      .count(b_count), .almost_full(b_af), .peak_count(b_peak));

   type_parameterized_fifo #(.DATA_TYPE(rgb_color_t), .DEPTH(3)) u_rgb (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(r_in_valid), .in_ready(r_in_ready), .in_data(r_in_data),
      .out_valid(r_out_valid), .out_ready(r_out_ready), .out_data(r_out_data),
      .count(r_count), .almost_full(r_af), .peak_count(r_peak));

   type_parameterized_fifo #(.DATA_TYPE(coordinate_t), .DEPTH(3)) u_coord (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
      .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
      .count(c_count), .almost_full(c_af), .peak_count(c_peak));

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      bit         iv;
      bit         ordy;
      logic [7:0] d;
      int         cnt;
      bit         ir;
      bit         ov;
      bit         af;
      logic [7:0] od;
      int         pk;
   } vec_t;

   vec_t vecs[15];

   function automatic vec_t mk(bit iv, bit ordy, logic [7:0] d, int cnt, bit ir,
                               bit ov, bit af, logic [7:0] od, int pk);
      vec_t v;
      v.iv = iv; v.ordy = ordy; v.d = d; v.cnt = cnt; v.ir = ir;
      v.ov = ov; v.af = af; v.od = od; v.pk = pk;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_all();
      flush = 0;
      b_in_valid = 0; b_out_ready = 0; b_in_data = '0;
      r_in_valid = 0; r_out_ready = 0; r_in_data = '0;
      c_in_valid = 0; c_out_ready = 0; c_in_data = '0;
   endtask

   task automatic do_reset();
      reset = 1;
      step();
      reset = 0;
      #1;
   endtask

   logic [7:0]  q[$];
   coordinate_t cq[$];
   int          peak_m;

   initial begin
      reset = 1;
      idle_all();
      step();
      step();
      // reset state, sampled while reset is still high
      chk("rst_count", 64'(b_count), 0);
      chk("rst_peak", 64'(b_peak), 0);
      chk("rst_in_ready", 64'(b_in_ready), 0);
      chk("rst_out_valid", 64'(b_out_valid), 0);
      chk("rst_af", 64'(b_af), 0);
      chk("rst_out_data", 64'(b_out_data), 0);
      reset = 0;
      #1;
      chk("post_rst_in_ready", 64'(b_in_ready), 1);

      // fill/drain, full blocking with simultaneous pop, refill to full
      vecs[0]  = mk(1, 0, 8'hA1, 1, 1, 1, 0, 8'hA1, 1);
      vecs[1]  = mk(1, 0, 8'hA2, 2, 1, 1, 0, 8'hA1, 2);
      vecs[2]  = mk(1, 0, 8'hA3, 3, 1, 1, 1, 8'hA1, 3);
      vecs[3]  = mk(1, 0, 8'hA4, 4, 0, 1, 1, 8'hA1, 4);
      vecs[4]  = mk(1, 0, 8'hEE, 4, 0, 1, 1, 8'hA1, 4);
      vecs[5]  = mk(0, 1, 8'h00, 3, 1, 1, 1, 8'hA2, 4);
      vecs[6]  = mk(0, 1, 8'h00, 2, 1, 1, 0, 8'hA3, 4);
      vecs[7]  = mk(0, 1, 8'h00, 1, 1, 1, 0, 8'hA4, 4);
      vecs[8]  = mk(0, 1, 8'h00, 0, 1, 0, 0, 8'h00, 4);
      vecs[9]  = mk(1, 0, 8'hB1, 1, 1, 1, 0, 8'hB1, 4);
      vecs[10] = mk(1, 0, 8'hB2, 2, 1, 1, 0, 8'hB1, 4);
      vecs[11] = mk(1, 0, 8'hB3, 3, 1, 1, 1, 8'hB1, 4);
      vecs[12] = mk(1, 0, 8'hB4, 4, 0, 1, 1, 8'hB1, 4);
      vecs[13] = mk(1, 1, 8'hC0, 3, 1, 1, 1, 8'hB2, 4);
      vecs[14] = mk(1, 0, 8'hC0, 4, 0, 1, 1, 8'hB2, 4);
      for (int i = 0; i < 15; i++) begin
         b_in_valid = vecs[i].iv; b_out_ready = vecs[i].ordy; b_in_data = vecs[i].d;
         step();
         $display("vec %0d: count=%0d in_ready=%0b out_valid=%0b af=%0b out=%h peak=%0d",
                  i, b_count, b_in_ready, b_out_valid, b_af, b_out_data, b_peak);
         chk("vec_count", 64'(b_count), 64'(vecs[i].cnt));
         chk("vec_in_ready", 64'(b_in_ready), 64'(vecs[i].ir));
         chk("vec_out_valid", 64'(b_out_valid), 64'(vecs[i].ov));
         chk("vec_af", 64'(b_af), 64'(vecs[i].af));
         chk("vec_peak", 64'(b_peak), 64'(vecs[i].pk));
         if (vecs[i].ov) chk("vec_out_data", 64'(b_out_data), 64'(vecs[i].od));
      end
      idle_all();

      // flush vs push
      do_reset();
      b_in_valid = 1; b_in_data = 8'h11; step();
      b_in_data = 8'h22; step();
      chk("fl_pre_peak", 64'(b_peak), 2);
      flush = 1; b_in_data = 8'h55; step();
      flush = 0; b_in_valid = 0;
      $display("flush: count=%0d out_valid=%0b af=%0b peak=%0d", b_count, b_out_valid, b_af, b_peak);
      chk("fl_count", 64'(b_count), 0);
      chk("fl_out_valid", 64'(b_out_valid), 0);
      chk("fl_af", 64'(b_af), 0);
      chk("fl_peak", 64'(b_peak), 2);
      b_in_valid = 1; b_in_data = 8'h66; step();
      b_in_valid = 0;
      chk("fl_next_data", 64'(b_out_data), 64'h66);
      chk("fl_next_count", 64'(b_count), 1);

      // reset mid-operation with count=3
      b_in_valid = 1; b_in_data = 8'h77; step();
      b_in_data = 8'h88; step();
      b_in_valid = 0;
      chk("mr_pre_count", 64'(b_count), 3);
      reset = 1; step();
      $display("mid reset: count=%0d peak=%0d out_valid=%0b in_ready=%0b", b_count, b_peak, b_out_valid, b_in_ready);
      chk("mr_count", 64'(b_count), 0);
      chk("mr_peak", 64'(b_peak), 0);
      chk("mr_out_valid", 64'(b_out_valid), 0);
      chk("mr_out_data", 64'(b_out_data), 0);
      chk("mr_in_ready", 64'(b_in_ready), 0);
      reset = 0; step();
      chk("mr_after_in_ready", 64'(b_in_ready), 1);
      chk("mr_after_count", 64'(b_count), 0);
      chk("mr_after_out_data", 64'(b_out_data), 0);

      // typed struct through rgb FIFO
      r_in_valid = 1; r_in_data = '{red: 8'hFF, green: 8'h80, blue: 8'h40}; step();
      $display("rgb push1: out=%h", r_out_data);
      chk("rgb_red", 64'(r_out_data.red), 64'hFF);
      chk("rgb_green", 64'(r_out_data.green), 64'h80);
      chk("rgb_blue", 64'(r_out_data.blue), 64'h40);
      r_in_data = '{red: 8'h01, green: 8'h02, blue: 8'h03}; step();
      r_in_valid = 0;
      chk("rgb_count", 64'(r_count), 2);
      chk("rgb_af", 64'(r_af), 1);
      chk("rgb_peak", 64'(r_peak), 2);
      r_out_ready = 1; step();
      r_out_ready = 0;
      $display("rgb pop1: out=%h", r_out_data);
      chk("rgb_second", 64'(r_out_data), 64'h010203);
      chk("rgb_valid", 64'(r_out_valid), 1);
      chk("rgb_in_ready", 64'(r_in_ready), 1);

      // wrap with concurrent push/pop on coordinate FIFO
      for (int i = 0; i < 2; i++) begin
         c_in_valid = 1; c_in_data = '{x: 16'(16'h1000 + i), y: 16'(16'h2000 + i)};
         cq.push_back(c_in_data);
         step();
      end
      for (int i = 2; i < 9; i++) begin
         c_in_valid = 1; c_out_ready = 1;
         c_in_data = '{x: 16'(16'h1000 + i), y: 16'(16'h2000 + i)};
         #1;
         chk("crd_x", 64'(c_out_data.x), 64'(cq[0].x));
         chk("crd_y", 64'(c_out_data.y), 64'(cq[0].y));
         void'(cq.pop_front());
         cq.push_back(c_in_data);
         step();
         $display("coord cycle %0d: count=%0d out_x=%h", i, c_count, c_out_data.x);
         chk("crd_count", 64'(c_count), 2);
      end
      c_in_valid = 0; c_out_ready = 0;
      chk("crd_peak", 64'(c_peak), 2);
      chk("crd_af", 64'(c_af), 1);
      chk("crd_in_ready", 64'(c_in_ready), 1);
      chk("crd_valid", 64'(c_out_valid), 1);

      // randomized run against queue model
      do_reset();
      q.delete();
      peak_m = 0;
      for (int i = 0; i < 400; i++) begin
         logic iv, ordy, fl, exp_ir, do_push, do_pop;
         logic [7:0] d;
         iv = 1'($urandom_range(0, 1));
         ordy = 1'($urandom_range(0, 1));
         fl = ($urandom_range(0, 15) == 0);
         d = 8'($urandom);
         b_in_valid = iv; b_out_ready = ordy; flush = fl; b_in_data = d;
         #1;
         exp_ir = (q.size() < 4);
         chk("rnd_in_ready", 64'(b_in_ready), 64'(exp_ir));
         chk("rnd_out_valid", 64'(b_out_valid), 64'(q.size() != 0));
         if (q.size() != 0) chk("rnd_out_data", 64'(b_out_data), 64'(q[0]));
         do_push = iv && exp_ir;
         do_pop = ordy && (q.size() != 0);
         if (fl) q.delete();
         else begin
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back(d);
         end
         if (q.size() > peak_m) peak_m = q.size();
         step();
         $display("rnd %0d: iv=%0b ordy=%0b fl=%0b d=%h count=%0d peak=%0d", i, iv, ordy, fl, d, b_count, b_peak);
         chk("rnd_count", 64'(b_count), 64'(q.size()));
         chk("rnd_peak", 64'(b_peak), 64'(peak_m));
         chk("rnd_af", 64'(b_af), 64'(q.size() >= 3));
      end
      idle_all();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
